// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and default bus widths for the APB initiator
package apb_pkg;

  localparam int APB_W_ADDR = 16;
  localparam int APB_W_DATA = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_RESP   = ST_RESP
  } apb_state_t;

endpackage

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - APB3 requester, one transfer outstanding, buffered response
// Optional ACCESS-phase timeout compiled in with APB_INITIATOR_TIMEOUT_EN.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int W_ADDR         = APB_W_ADDR,
  parameter int W_DATA         = APB_W_DATA,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W_DATA-1:0] resp_rdata,
  output logic              resp_err,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [W_ADDR-1:0] apbm_paddr,
  output logic [W_DATA-1:0] apbm_pwdata,
  input  logic [W_DATA-1:0] apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
);

  apb_state_t state, state_nxt;
  logic       timeout_hit;

`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int W_CNT = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT_CYCLES - 1);

  logic [W_CNT-1:0] cnt;

  // Fires on the last allowed wait cycle; pready on that same cycle still wins.
  assign timeout_hit = (state == S_ACCESS) && !apbm_pready && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_SETUP) begin
      cnt <= '0;
    end else if (state == S_ACCESS && !apbm_pready) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (apbm_pready || timeout_hit) state_nxt = S_RESP;
      S_RESP:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bus control strobes follow the state register directly, so they drop on reset.
  assign req_ready    = (state == S_IDLE);
  assign apbm_psel    = (state == S_SETUP) || (state == S_ACCESS);
  assign apbm_penable = (state == S_ACCESS);
  assign resp_valid   = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      apbm_pwrite <= 1'b0;
      apbm_paddr  <= '0;
      apbm_pwdata <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        apbm_pwrite <= req_write;
        apbm_paddr  <= req_addr;
        apbm_pwdata <= req_wdata;
      end
      if (state == S_ACCESS) begin
        if (apbm_pready) begin
          resp_rdata <= apbm_pwrite ? '0 : apbm_prdata;
          resp_err   <= apbm_pslverr;
        end else if (timeout_hit) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
      end
    end
  end

endmodule
